sdc_close_sequencer: RTL and testbench

- Synchronous controller that sequences closing of the shutdown circuit (SDC) for autonomous operation.
- Monitors the AS computer heartbeat and generates the Watchdog level and the external watchdog kick.
- Drives AS_close_SDC into the SDC latch block only after the SDC reports ready. It then supervises relay feedback and opens on any fault.
- Sits between the AS computer interface and the SDC latch/relay block.

---
 rtl/sdc_pkg.sv | 24 ++
 rtl/sdc_hb_monitor.sv | 66 ++++++
 rtl/sdc_close_sequencer.sv | 120 ++++++++++++
 tb/tb_sdc_close_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdc_pkg.sv
// Shared types and default timing for the SDC close sequencer.
package sdc_pkg;

    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        IDLE     = 3'd0,
        PRECHECK = 3'd1,
        ARMED    = 3'd2,
        CLOSED   = 3'd3,
        OPEN     = 3'd4
    } seq_state_e;

    localparam int HB_TIMEOUT_DEF    = 50000;
    localparam int WD_HALF_DEF       = 500;
    localparam int READY_SETTLE_DEF  = 16;
    localparam int CLOSE_TIMEOUT_DEF = 20000;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdc_hb_monitor.sv
// Heartbeat supervision, watchdog-healthy level and external watchdog kick.
module sdc_hb_monitor
    import sdc_pkg::*;
#(
    parameter int HB_TIMEOUT = HB_TIMEOUT_DEF,
    parameter int WD_HALF    = WD_HALF_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic heartbeat_i,
    input  logic fsm_open_i,
    output logic hb_ok_o,
    output logic watchdog_o,
    output logic wd_kick_o
);

    localparam int                HB_W     = cnt_width(HB_TIMEOUT + 1);
    localparam logic [HB_W-1:0]   HB_LIMIT = HB_W'(HB_TIMEOUT);
    localparam int                WD_W     = cnt_width(WD_HALF);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(WD_HALF - 1);

    logic [HB_W-1:0] hb_cnt_q;
    logic            hb_ok_q;
    logic            watchdog_q;
    logic [WD_W-1:0] wd_cnt_q;
    logic            wd_kick_q;

    // Heartbeat age counter; a pulse on the limit cycle still keeps hb_ok.
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt_q <= '0;
            hb_ok_q  <= 1'b0;
        end else if (heartbeat_i) begin
            hb_cnt_q <= '0;
            hb_ok_q  <= 1'b1;
        end else if (hb_cnt_q == HB_LIMIT) begin
            hb_ok_q  <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_q + 1'b1;
        end
    end

    // Watchdog level drops when the heartbeat is lost or the SDC is opened.
    always_ff @(posedge clk) begin
        if (rst) watchdog_q <= 1'b0;
        else     watchdog_q <= hb_ok_q && !fsm_open_i;
    end

    // Square wave for the external watchdog, frozen low while unhealthy.
    always_ff @(posedge clk) begin
        if (rst || !watchdog_q) begin
            wd_cnt_q  <= '0;
            wd_kick_q <= 1'b0;
        end else if (wd_cnt_q == WD_LAST) begin
            wd_cnt_q  <= '0;
            wd_kick_q <= ~wd_kick_q;
        end else begin
            wd_cnt_q  <= wd_cnt_q + 1'b1;
        end
    end

    assign hb_ok_o    = hb_ok_q;
    assign watchdog_o = watchdog_q;
    assign wd_kick_o  = wd_kick_q;

endmodule

// File: rtl/sdc_close_sequencer.sv
// SDC close sequencer: arms and closes the shutdown circuit for autonomous
// operation and opens it on any fault.
//
//   state    | meaning
//   IDLE     | waiting for mission selection with a healthy heartbeat
//   PRECHECK | waiting for SDC ready to stay high long enough
//   ARMED    | close requested, waiting for relay feedback
//   CLOSED   | SDC closed, supervising feedback, ready and mission
//   OPEN     | fault, terminal until reset
module sdc_close_sequencer
    import sdc_pkg::*;
#(
    parameter int HB_TIMEOUT    = HB_TIMEOUT_DEF,
    parameter int WD_HALF       = WD_HALF_DEF,
    parameter int READY_SETTLE  = READY_SETTLE_DEF,
    parameter int CLOSE_TIMEOUT = CLOSE_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   Power_on_Reset,
    input  logic                   as_mission_selected,
    input  logic                   as_heartbeat,
    input  logic                   as_emergency,
    input  logic                   sdc_is_ready,
    input  logic                   sdc_relais_fb,
    output logic                   AS_close_SDC,
    output logic                   Watchdog,
    output logic                   wd_kick,
    output logic [SEQ_STATE_W-1:0] seq_state,
    output logic                   sdc_fault,
    output logic                   close_timeout
);

    localparam int               SET_W     = cnt_width(READY_SETTLE);
    localparam logic [SET_W-1:0] SET_LAST  = SET_W'(READY_SETTLE - 1);
    localparam int               CLS_W     = cnt_width(CLOSE_TIMEOUT);
    localparam logic [CLS_W-1:0] CLS_LAST  = CLS_W'(CLOSE_TIMEOUT - 1);

    seq_state_e       state_q, state_d;
    logic             timeout_set_d;
    logic             close_q, fault_q, timeout_q;
    logic [SET_W-1:0] settle_cnt_q;
    logic [CLS_W-1:0] close_cnt_q;
    logic             hb_ok;

    sdc_hb_monitor #(
        .HB_TIMEOUT (HB_TIMEOUT),
        .WD_HALF    (WD_HALF)
    ) u_hb_monitor (
        .clk         (clk),
        .rst         (Power_on_Reset),
        .heartbeat_i (as_heartbeat),
        .fsm_open_i  (state_q == OPEN),
        .hb_ok_o     (hb_ok),
        .watchdog_o  (Watchdog),
        .wd_kick_o   (wd_kick)
    );

    // Next-state decode; abort beats every other exit, feedback beats timeout.
    always_comb begin
        state_d       = state_q;
        timeout_set_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (as_mission_selected && hb_ok) state_d = PRECHECK;
            end
            PRECHECK: begin
                if (as_emergency || !hb_ok)              state_d = OPEN;
                else if (!as_mission_selected)           state_d = IDLE;
                else if (sdc_is_ready && settle_cnt_q == SET_LAST)
                                                         state_d = ARMED;
            end
            ARMED: begin
                if (as_emergency || !hb_ok)      state_d = OPEN;
                else if (sdc_relais_fb)          state_d = CLOSED;
                else if (close_cnt_q == CLS_LAST) begin
                    state_d       = OPEN;
                    timeout_set_d = 1'b1;
                end
            end
            CLOSED: begin
                if (as_emergency || !hb_ok || !sdc_relais_fb ||
                    !sdc_is_ready || !as_mission_selected)
                    state_d = OPEN;
            end
            OPEN:    state_d = OPEN;
            default: state_d = OPEN;
        endcase
    end

    // State, registered outputs and the settle/close timers.
    always_ff @(posedge clk) begin
        if (Power_on_Reset) begin
            state_q      <= IDLE;
            close_q      <= 1'b0;
            fault_q      <= 1'b0;
            timeout_q    <= 1'b0;
            settle_cnt_q <= '0;
            close_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            close_q   <= (state_d == ARMED) || (state_d == CLOSED);
            fault_q   <= (state_d == OPEN);
            timeout_q <= timeout_q | timeout_set_d;
            if (state_q == PRECHECK && state_d == PRECHECK && sdc_is_ready)
                settle_cnt_q <= settle_cnt_q + 1'b1;
            else
                settle_cnt_q <= '0;
            if (state_q == ARMED && state_d == ARMED)
                close_cnt_q <= close_cnt_q + 1'b1;
            else
                close_cnt_q <= '0;
        end
    end

    assign seq_state     = state_q;
    assign AS_close_SDC  = close_q;
    assign sdc_fault     = fault_q;
    assign close_timeout = timeout_q;

endmodule

// File: tb/tb_sdc_close_sequencer.sv
// Scoreboard bench for sdc_close_sequencer with shortened timing.
module tb_sdc_close_sequencer;
    import sdc_pkg::*;

    localparam int HB_T = 200, WD_H = 5, RS = 4, CT = 50, HB_PERIOD = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       Power_on_Reset, as_mission_selected, as_emergency;
    logic       sdc_is_ready, sdc_relais_fb;
    logic       as_heartbeat = 1'b0;
    logic       AS_close_SDC, Watchdog, wd_kick, sdc_fault, close_timeout;
    logic [2:0] seq_state;

    sdc_close_sequencer #(
        .HB_TIMEOUT    (HB_T),
        .WD_HALF       (WD_H),
        .READY_SETTLE  (RS),
        .CLOSE_TIMEOUT (CT)
    ) dut (
        .clk                 (clk),
        .Power_on_Reset      (Power_on_Reset),
        .as_mission_selected (as_mission_selected),
        .as_heartbeat        (as_heartbeat),
        .as_emergency        (as_emergency),
        .sdc_is_ready        (sdc_is_ready),
        .sdc_relais_fb       (sdc_relais_fb),
        .AS_close_SDC        (AS_close_SDC),
        .Watchdog            (Watchdog),
        .wd_kick             (wd_kick),
        .seq_state           (seq_state),
        .sdc_fault           (sdc_fault),
        .close_timeout       (close_timeout)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       cl;
        logic       ft;
        logic       to;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    bit         mon_en = 1'b0;
    logic [2:0] prev_state = 3'd0;
    bit         hb_en = 1'b0;
    int         hb_at = -1;
    int         last_hb = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int c, input logic [2:0] st, input logic cl,
                        input logic ft, input logic to);
        exp_t e;
        e.cyc = c; e.st = st; e.cl = cl; e.ft = ft; e.to = to;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_watchdog(input int limit);
        int k = 0;
        while (Watchdog !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("watchdog_up", 32'(Watchdog), 32'd1);
    endtask

    // Heartbeat source: periodic pulses plus one scheduled pulse at hb_at.
    always @(negedge clk) begin
        as_heartbeat = (hb_en && (cyc % HB_PERIOD == 0)) || (cyc == hb_at);
        if (as_heartbeat) last_hb = cyc;
    end

    // Monitor: every state change pops one expected transition.
    always @(negedge clk) begin
        if (mon_en && seq_state != prev_state) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_transition: got state %0d at cycle %0d, expected none",
                         seq_state, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk($sformatf("event_cycle(state %0d)", mon_e.st), 32'(cyc), 32'(mon_e.cyc));
                chk("event_outputs{state,close,fault,timeout}",
                    32'({seq_state, AS_close_SDC, sdc_fault, close_timeout}),
                    32'({mon_e.st, mon_e.cl, mon_e.ft, mon_e.to}));
            end
        end
        prev_state = seq_state;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish by cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int c, w, L, L2, k;
        Power_on_Reset = 1'b1;
        repeat (3) begin
            as_mission_selected = 1'($urandom_range(0, 1));
            as_emergency        = 1'($urandom_range(0, 1));
            sdc_is_ready        = 1'($urandom_range(0, 1));
            sdc_relais_fb       = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("rst_state",   32'(seq_state),     32'd0);
        chk("rst_close",   32'(AS_close_SDC),  32'd0);
        chk("rst_wd",      32'(Watchdog),      32'd0);
        chk("rst_kick",    32'(wd_kick),       32'd0);
        chk("rst_fault",   32'(sdc_fault),     32'd0);
        chk("rst_timeout", 32'(close_timeout), 32'd0);
        Power_on_Reset = 1'b0;
        as_mission_selected = 1'b0; as_emergency = 1'b0;
        sdc_is_ready = 1'b0; sdc_relais_fb = 1'b0;
        mon_en = 1'b1;

        // first heartbeat -> Watchdog two cycles after it is sampled, then kick
        c = cyc; hb_at = c + 2;
        wait_until(c + 3); chk("wd_one_cycle_after_hb", 32'(Watchdog), 32'd0);
        wait_until(c + 4); chk("wd_two_cycles_after_hb", 32'(Watchdog), 32'd1);
        w = c + 4;
        wait_until(w + 4);  chk("kick_before_half", 32'(wd_kick), 32'd0);
        wait_until(w + 5);  chk("kick_first_toggle", 32'(wd_kick), 32'd1);
        wait_until(w + 10); chk("kick_second_toggle", 32'(wd_kick), 32'd0);
        hb_en = 1'b1;

        // happy path
        c = cyc;
        as_mission_selected = 1'b1; sdc_is_ready = 1'b1;
        push(c + 1,  PRECHECK, 1'b0, 1'b0, 1'b0);
        push(c + 5,  ARMED,    1'b1, 1'b0, 1'b0);
        push(c + 16, CLOSED,   1'b1, 1'b0, 1'b0);
        wait_until(c + 15); sdc_relais_fb = 1'b1;
        wait_until(c + 17);
        chk("closed_fault", 32'(sdc_fault), 32'd0);
        chk("closed_wd",    32'(Watchdog),  32'd1);

        // heartbeat at exactly the limit, then heartbeat loss in CLOSED
        while (cyc % HB_PERIOD != 50) @(negedge clk);
        hb_en = 1'b0;
        @(negedge clk);
        L = last_hb; L2 = L + 201; hb_at = L2;
        push(L2 + 203, OPEN, 1'b0, 1'b1, 1'b0);
        wait_until(L + 206);
        chk("hb_at_limit_state", 32'(seq_state), 32'(CLOSED));
        chk("hb_at_limit_wd",    32'(Watchdog),  32'd1);
        wait_until(L2 + 202); chk("wd_last_healthy", 32'(Watchdog), 32'd1);
        wait_until(L2 + 203); chk("wd_after_loss",   32'(Watchdog), 32'd0);
        wait_until(L2 + 205); chk("kick_frozen_a",   32'(wd_kick),  32'd0);
        wait_until(L2 + 220); chk("kick_frozen_b",   32'(wd_kick),  32'd0);

        // reset out of OPEN
        c = cyc; Power_on_Reset = 1'b1;
        push(c + 1, IDLE, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        Power_on_Reset = 1'b0; as_mission_selected = 1'b0; sdc_relais_fb = 1'b0;
        chk("rst_open_fault",   32'(sdc_fault),     32'd0);
        chk("rst_open_timeout", 32'(close_timeout), 32'd0);
        chk("rst_open_wd",      32'(Watchdog),      32'd0);

        // ready glitch in PRECHECK, then close timeout
        hb_at = cyc + 2; hb_en = 1'b1;
        wait_watchdog(20);
        c = cyc; as_mission_selected = 1'b1; sdc_is_ready = 1'b1;
        push(c + 1,  PRECHECK, 1'b0, 1'b0, 1'b0);
        push(c + 8,  ARMED,    1'b1, 1'b0, 1'b0);
        push(c + 58, OPEN,     1'b0, 1'b1, 1'b1);
        wait_until(c + 3); sdc_is_ready = 1'b0;
        wait_until(c + 4); sdc_is_ready = 1'b1;
        wait_until(c + 58); chk("wd_at_timeout", 32'(Watchdog), 32'd1);
        wait_until(c + 59); chk("wd_after_timeout", 32'(Watchdog), 32'd0);
        chk("timeout_flag", 32'(close_timeout), 32'd1);

        // emergency together with feedback in ARMED
        c = cyc; Power_on_Reset = 1'b1;
        push(c + 1, IDLE, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        Power_on_Reset = 1'b0; as_mission_selected = 1'b0;
        wait_watchdog(150);
        c = cyc; as_mission_selected = 1'b1;
        push(c + 1, PRECHECK, 1'b0, 1'b0, 1'b0);
        push(c + 5, ARMED,    1'b1, 1'b0, 1'b0);
        push(c + 8, OPEN,     1'b0, 1'b1, 1'b0);
        wait_until(c + 7); sdc_relais_fb = 1'b1; as_emergency = 1'b1;
        wait_until(c + 9); chk("emerg_no_timeout", 32'(close_timeout), 32'd0);

        // emergency ignored in IDLE, then ready drop in CLOSED
        c = cyc; Power_on_Reset = 1'b1;
        push(c + 1, IDLE, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        Power_on_Reset = 1'b0; as_mission_selected = 1'b0; sdc_relais_fb = 1'b0;
        wait_watchdog(150);
        repeat (20) @(negedge clk);
        chk("idle_emerg_state", 32'(seq_state), 32'(IDLE));
        chk("idle_emerg_fault", 32'(sdc_fault), 32'd0);
        c = cyc;
        as_emergency = 1'b0; as_mission_selected = 1'b1;
        sdc_is_ready = 1'b1; sdc_relais_fb = 1'b1;
        push(c + 1,  PRECHECK, 1'b0, 1'b0, 1'b0);
        push(c + 5,  ARMED,    1'b1, 1'b0, 1'b0);
        push(c + 6,  CLOSED,   1'b1, 1'b0, 1'b0);
        push(c + 10, OPEN,     1'b0, 1'b1, 1'b0);
        wait_until(c + 9); sdc_is_ready = 1'b0;
        wait_until(c + 11);

        k = 0;
        while (exp_q.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_chk++;
            $display("FAIL missing_transition: got none, expected state %0d at cycle %0d",
                     mon_e.st, mon_e.cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
